// File: rtl/lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: funct3 codes, FSM states,
// access-size decode, alignment check and sub-word store merge.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRd   = 2'd1,
      StWr   = 2'd2,
      StResp = 2'd3
   } lsu_state_e;

   // Size comes from funct3[1:0]; every code that is neither byte nor half is word-sized.
   function automatic logic is_byte(input logic [2:0] f3);
      return f3[1:0] == 2'b00;
   endfunction

   function automatic logic is_half(input logic [2:0] f3);
      return f3[1:0] == 2'b01;
   endfunction

   function automatic logic is_misaligned(input logic [1:0] off, input logic [2:0] f3);
      if (is_byte(f3)) return 1'b0;
      if (is_half(f3)) return off[0];
      return off != 2'b00;
   endfunction

   function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [15:0] wd,
                                              input logic [1:0] off, input logic [2:0] f3);
      logic [31:0] r;
      r = word;
      if (is_byte(f3)) r[{off, 3'b000} +: 8] = wd[7:0];
      else if (is_half(f3)) r[{off[1], 4'b0000} +: 16] = wd;
      return r;
   endfunction

endpackage

// File: rtl/lsu_load_extract.sv
// Load data lane select and sign/zero extension from a full memory word.
module lsu_load_extract
   import lsu_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  off_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      byte_lane = word_i[{off_i, 3'b000} +: 8];
      half_lane = word_i[{off_i[1], 4'b0000} +: 16];
      data_o    = word_i;
      if (is_byte(funct3_i)) begin
         data_o = {{24{byte_lane[7] & ~funct3_i[2]}}, byte_lane};
      end else if (is_half(funct3_i)) begin
         data_o = {{16{half_lane[15] & ~funct3_i[2]}}, half_lane};
      end
   end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit driving a word-wide data memory; sub-word stores use read-modify-write.
// Define DMEM_LSU_MISALIGN_TRAP_EN to reject misaligned accesses with resp_err.
module dmem_lsu
   import lsu_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_a,
   output logic [31:0]       mem_wd,
   input  logic [31:0]       mem_rd
);

   lsu_state_e        state_q, state_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [1:0]        off_q, off_d;
   logic [15:0]       wdata_q, wdata_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] mem_a_q, mem_a_d;
   logic [31:0]       mem_wd_q, mem_wd_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [31:0]       load_data;
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
   logic              err_q, err_d;
`endif

   lsu_load_extract u_extract (
      .word_i   (mem_rd),
      .off_i    (off_q),
      .funct3_i (funct3_q),
      .data_o   (load_data)
   );

   always_comb begin
      state_d  = state_q;
      funct3_d = funct3_q;
      off_d    = off_q;
      wdata_d  = wdata_q;
      we_d     = we_q;
      mem_a_d  = mem_a_q;
      mem_wd_d = mem_wd_q;
      rdata_d  = rdata_q;
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
      err_d    = err_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               funct3_d = req_funct3;
               off_d    = req_addr[1:0];
               wdata_d  = req_wdata[15:0];
               we_d     = req_we;
               mem_a_d  = {req_addr[ADDR_W-1:2], 2'b00};
               if (req_we && !is_byte(req_funct3) && !is_half(req_funct3)) begin
                  mem_wd_d = req_wdata;
                  state_d  = StWr;
               end else begin
                  state_d = StRd;
               end
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
               // Rejected requests leave the memory port untouched.
               if (is_misaligned(req_addr[1:0], req_funct3)) begin
                  mem_a_d  = mem_a_q;
                  mem_wd_d = mem_wd_q;
                  err_d    = 1'b1;
                  state_d  = StResp;
               end
`endif
            end
         end
         StRd: begin
            if (we_q) begin
               mem_wd_d = lane_merge(mem_rd, wdata_q, off_q, funct3_q);
               state_d  = StWr;
            end else begin
               rdata_d = load_data;
               state_d = StResp;
            end
         end
         StWr: state_d = StResp;
         StResp: begin
            // Clear so resp_rdata/resp_err read 0 outside a response.
            rdata_d = '0;
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
            err_d   = 1'b0;
`endif
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         funct3_q <= '0;
         off_q    <= '0;
         wdata_q  <= '0;
         we_q     <= 1'b0;
         mem_a_q  <= '0;
         mem_wd_q <= '0;
         rdata_q  <= '0;
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         funct3_q <= funct3_d;
         off_q    <= off_d;
         wdata_q  <= wdata_d;
         we_q     <= we_d;
         mem_a_q  <= mem_a_d;
         mem_wd_q <= mem_wd_d;
         rdata_q  <= rdata_d;
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
         err_q    <= err_d;
`endif
      end
   end

   assign req_ready  = (state_q == StIdle);
   assign resp_valid = (state_q == StResp);
   assign mem_we     = (state_q == StWr);
   assign mem_a      = mem_a_q;
   assign mem_wd     = mem_wd_q;
   assign resp_rdata = rdata_q;
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
   assign resp_err   = err_q;
`else
   assign resp_err   = 1'b0;
`endif

endmodule
